rom_string_sender: RTL and testbench
====================================

Name: rom_string_sender

Overview:
Sequencer that walks a null-terminated string held in the team's 16x8 synchronous ROM and streams it, one byte at a time, to a UART transmitter over a valid/ready handshake.
- Sits between the ROM (it drives the address and reads the data) and the UART TX block.
- A single start pulse sends a whole message; completion is signalled with a done pulse.

Parameters:
- ADDR_W, 4: ROM address width.
- DATA_W, 8: ROM/UART byte width.
- START_ADDR, 0: first ROM address of the message.
- MAX_LEN, 16: maximum bytes sent per message. Sending stops after MAX_LEN bytes even if no NUL was seen. Range 1..2^ADDR_W.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle request to send the message; ignored while busy_o=1.
- rom_addr_o  out  ADDR_W  registered ROM address.
- rom_data_i  in  DATA_W  ROM read data, valid one cycle after rom_addr_o changes.
- tx_data_o  out  DATA_W  byte offered to UART.
- tx_valid_o  out  1  byte offered; held until accepted.
- tx_ready_i  in  1  UART can accept; transfer when tx_valid_o&&tx_ready_i at rising edge.
- busy_o  out  1  high from the cycle after start is accepted until DONE exits.
- done_o  out  1  one-cycle pulse at end of message.
- count_o  out  ADDR_W+1  bytes transferred in the current/last message; excludes the NUL and any CR/LF.

Behaviour:
- Reset, asynchronous: state=IDLE; rom_addr_o=START_ADDR, tx_data_o=0, tx_valid_o=0, busy_o=0, done_o=0, count_o=0.
  - Reset mid-message aborts immediately; no partial handshake is preserved.
- IDLE:
  - On start_i: rom_addr_o<=START_ADDR, count_o<=0, go to FETCH.
- FETCH: ROM samples rom_addr_o at the end of this cycle; go to LATCH.
- LATCH: rom_data_i is valid.
  - If rom_data_i==0: go to DONE.
  - Else: tx_data_o<=rom_data_i, tx_valid_o<=1, go to SEND.
- SEND: hold tx_data_o and tx_valid_o stable until tx_ready_i=1. On transfer:
  - tx_valid_o<=0 and count_o<=count_o+1.
  - If count_o+1==MAX_LEN: go to DONE.
  - Else: rom_addr_o<=rom_addr_o+1, wrapping modulo 2^ADDR_W (15->0), and go to FETCH.
- DONE: done_o=1 for exactly this cycle; rom_addr_o<=START_ADDR; go to IDLE.
- busy_o=1 in FETCH, LATCH, SEND and DONE.
- Latency:
  - start_i sampled at edge N -> tx_valid_o high in cycle N+3.
  - With tx_ready_i tied high: 3 cycles per byte.
  - Empty string (NUL at START_ADDR): done_o in cycle N+3; tx_valid_o never asserts.
- start_i while busy: dropped, not queued.
- start_i in the same cycle as DONE: dropped.
- tx_ready_i high while tx_valid_o=0: ignored.

Optional Feature:
- Macro: ROM_STRING_SENDER_CRLF_EN.
- Defined: after the terminating NUL or MAX_LEN stop, the block sends 0x0D then 0x0A through states CR and LF before DONE.
  - Each uses the same valid/ready rules as SEND.
  - CR/LF are not counted in count_o.
  - Empty string sends CR, LF only.
- Undefined: the CR/LF states and logic are absent; LATCH/SEND go directly to DONE.

Decomposition:
- Package rom_string_sender_pkg:
  - state enum (IDLE, FETCH, LATCH, SEND, CR, LF, DONE);
  - constants CHR_NUL=8'h00, CHR_CR=8'h0D, CHR_LF=8'h0A.
- No sub-module: the FSM and datapath are small. The bench pairs the block with the team's 16x8 ROM.

Test Plan:
- ROM "Hi\0", ready tied high, start pulse at cycle 0:
  - tx bytes 0x48, 0x69 accepted at cycles 3 and 6;
  - done_o at cycle 9; count_o=2; busy_o low at cycle 10.
- Same ROM, ready low for 5 cycles after each valid:
  - tx_data_o/tx_valid_o stay stable while stalled;
  - exactly 2 transfers; no byte lost or duplicated.
- ROM with no NUL, 16 non-zero bytes, MAX_LEN=16: all 16 bytes sent in order, then done_o; count_o=16.
- START_ADDR=14, ROM[14]="A", ROM[15]="B", ROM[0]=0: sends "A","B"; rom_addr_o wraps 15->0; done_o; count_o=2.
- Empty string: done_o 3 cycles after start; tx_valid_o never high.
  - With ROM_STRING_SENDER_CRLF_EN: 0x0D, 0x0A, then done_o.
- Boundary events:
  - rst_i asserted in SEND: all outputs at reset values without a clock edge.
  - start_i pulsed mid-message: ignored; only one done_o.

Source files
------------

// File: rtl/rom_string_sender_pkg.sv
// Shared types and character constants for the ROM string sender.
package rom_string_sender_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [7:0] CHR_NUL = 8'h00;
  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;

endpackage

// File: rtl/rom_string_sender.sv
// Walks a NUL-terminated string in a synchronous ROM and streams each byte
// to a UART transmitter over a valid/ready handshake.
// Optional build macro ROM_STRING_SENDER_CRLF_EN appends CR, LF (uncounted)
// after the message ends.
module rom_string_sender
  import rom_string_sender_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0,
  parameter int MAX_LEN    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W+1)'(MAX_LEN);

  // Where the message goes once the string is exhausted.
`ifdef ROM_STRING_SENDER_CRLF_EN
  localparam state_t END_ST = CR;
`else
  localparam state_t END_ST = DONE;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic                xfer_s;
  logic                is_nul_s;
  logic [ADDR_W:0]     count_inc_s;
  logic                last_byte_s;

  assign xfer_s      = tx_valid_q && tx_ready_i;
  assign is_nul_s    = (rom_data_i == DATA_W'(CHR_NUL));
  assign count_inc_s = count_q + CNT_ONE;
  assign last_byte_s = (count_inc_s == CNT_MAX);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
        else         state_d = IDLE;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        if (is_nul_s) state_d = END_ST;
        else          state_d = SEND;
      end
      SEND: begin
        if (xfer_s) begin
          if (last_byte_s) state_d = END_ST;
          else             state_d = FETCH;
        end else begin
          state_d = SEND;
        end
      end
`ifdef ROM_STRING_SENDER_CRLF_EN
      CR: begin
        if (xfer_s) state_d = LF;
        else        state_d = CR;
      end
      LF: begin
        if (xfer_s) state_d = DONE;
        else        state_d = LF;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    rom_addr_d = rom_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          rom_addr_d = START_A;
          count_d    = '0;
        end else begin
          count_d    = count_q;
        end
      end
      FETCH: begin
        rom_addr_d = rom_addr_q;
      end
      LATCH: begin
        if (!is_nul_s) begin
          tx_data_d  = rom_data_i;
          tx_valid_d = 1'b1;
        end else begin
`ifdef ROM_STRING_SENDER_CRLF_EN
          tx_data_d  = DATA_W'(CHR_CR);
          tx_valid_d = 1'b1;
`else
          tx_valid_d = 1'b0;
`endif
        end
      end
      SEND: begin
        if (xfer_s) begin
          count_d = count_inc_s;
          if (last_byte_s) begin
`ifdef ROM_STRING_SENDER_CRLF_EN
            tx_data_d  = DATA_W'(CHR_CR);
            tx_valid_d = 1'b1;
`else
            tx_valid_d = 1'b0;
`endif
          end else begin
            tx_valid_d = 1'b0;
            rom_addr_d = rom_addr_q + ADDR_ONE;
          end
        end else begin
          tx_valid_d = tx_valid_q;
        end
      end
`ifdef ROM_STRING_SENDER_CRLF_EN
      CR: begin
        if (xfer_s) tx_data_d = DATA_W'(CHR_LF);
        else        tx_data_d = tx_data_q;
      end
      LF: begin
        if (xfer_s) tx_valid_d = 1'b0;
        else        tx_valid_d = tx_valid_q;
      end
`endif
      DONE: begin
        rom_addr_d = START_A;
      end
      default: begin
        rom_addr_d = START_A;
        tx_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rom_addr_q <= START_A;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_rom_string_sender.sv
// Self-checking bench for rom_string_sender: two instances (message at ROM
// address 0 and at address 14) share one 16x8 ROM image.
module tb_rom_string_sender;

`ifdef ROM_STRING_SENDER_CRLF_EN
  localparam int CRLF = 1;
`else
  localparam int CRLF = 0;
`endif
  localparam int HI_DONE    = 9 + 2 * CRLF;
  localparam int EMPTY_DONE = 3 + 2 * CRLF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ready, sel;
  logic [7:0] rom_mem [16];
  logic [3:0] addr0, addr1;
  logic [7:0] rd0, rd1, txd0, txd1;
  logic       v0, v1, b0, b1, d0, d1;
  logic [4:0] c0, c1;

  // Synchronous 16x8 ROM, one read port per instance.
  always @(posedge clk) begin
    rd0 <= rom_mem[addr0];
    rd1 <= rom_mem[addr1];
  end

  rom_string_sender #(.ADDR_W(4), .DATA_W(8), .START_ADDR(0), .MAX_LEN(16)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .rom_addr_o(addr0),
    .rom_data_i(rd0), .tx_data_o(txd0), .tx_valid_o(v0), .tx_ready_i(ready),
    .busy_o(b0), .done_o(d0), .count_o(c0));

  rom_string_sender #(.ADDR_W(4), .DATA_W(8), .START_ADDR(14), .MAX_LEN(16)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .rom_addr_o(addr1),
    .rom_data_i(rd1), .tx_data_o(txd1), .tx_valid_o(v1), .tx_ready_i(ready & sel),
    .busy_o(b1), .done_o(d1), .count_o(c1));

  logic [7:0] tx_data;
  logic       tx_valid, busy, done;
  logic [3:0] rom_addr;
  logic [4:0] count;
  assign tx_data  = sel ? txd1 : txd0;
  assign tx_valid = sel ? v1 : v0;
  assign busy     = sel ? b1 : b0;
  assign done     = sel ? d1 : d0;
  assign rom_addr = sel ? addr1 : addr0;
  assign count    = sel ? c1 : c0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state updated once per cycle by tick().
  logic       fired = 1'b0;
  logic [7:0] obs[$];
  int         done_cnt;
  logic       saw_wrap;
  logic [3:0] prev_addr;

  task automatic tick();
    logic f, hold;
    logic [7:0] fd;
    f    = tx_valid && ready;
    fd   = tx_data;
    hold = tx_valid && !ready && !rst;
    @(posedge clk);
    #1;
    fired = f;
    if (f) obs.push_back(fd);
    if (done) done_cnt++;
    if (prev_addr == 4'd15 && rom_addr == 4'd0) saw_wrap = 1'b1;
    prev_addr = rom_addr;
    if (hold) begin
      chk("hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, fd});
    end
  endtask

  // Reference: bytes from base until NUL or 16 bytes, then optional CR/LF.
  logic [7:0] exp_q[$];
  int         exp_cnt;

  task automatic build_model(input int base);
    logic [7:0] b;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      b = rom_mem[(base + i) % 16];
      if (b == 8'h00) break;
      exp_q.push_back(b);
      exp_cnt++;
    end
    if (CRLF != 0) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic load_text(input string text, input int base);
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < text.len(); i++) rom_mem[(base + i) % 16] = text[i];
  endtask

  task automatic clear_mon();
    obs.delete();
    done_cnt  = 0;
    saw_wrap  = 1'b0;
    prev_addr = rom_addr;
  endtask

  // One message with a ready policy: stall<0 means random stall per byte.
  task automatic run_msg(input int s, input int stall, input logic noise, input string tag);
    int vcnt, cur, budget;
    sel = s[0];
    #1;
    clear_mon();
    build_model(s != 0 ? 14 : 0);
    vcnt = 0; cur = 0; budget = 0;
    start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    while (!done && budget < 500) begin
      if (fired) vcnt = 0;
      if (tx_valid) begin
        if (vcnt == 0) cur = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        ready = (vcnt >= cur);
        vcnt++;
      end else begin
        ready = $urandom_range(0, 1) != 0;
      end
      start = noise && ($urandom_range(0, 3) == 0);
      tick();
      budget++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_count"}, {27'd0, count}, exp_cnt);
    start = noise;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_pulses"}, done_cnt, 32'd1);
    chk({tag, "_nbytes"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, {24'd0, obs[i]}, {24'd0, exp_q[i]});
  endtask

  typedef struct {
    string text;
    int    sel;
    int    stall;
    logic  noise;
    int    exp_count;
  } vec_t;
  vec_t vecs[6];

  logic       vr[1:16], dr[1:16], br[1:16];
  logic [7:0] dd[1:16];

  task automatic record(input int ncyc);
    for (int c = 1; c <= ncyc; c++) begin
      vr[c] = tx_valid; dd[c] = tx_data; dr[c] = done; br[c] = busy;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, k;
    vecs[0] = '{"Hi", 0, 0, 1'b0, 2};
    vecs[1] = '{"Hi", 0, 5, 1'b0, 2};
    vecs[2] = '{"ABCDEFGHIJKLMNOP", 0, 0, 1'b0, 16};
    vecs[3] = '{"AB", 1, -1, 1'b0, 2};
    vecs[4] = '{"", 0, 0, 1'b0, 0};
    vecs[5] = '{"Hello", 0, 2, 1'b1, 5};

    rst = 1'b1; start = 1'b0; ready = 1'b0; sel = 1'b0;
    load_text("", 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", {28'd0, rom_addr}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_addr_u1", {28'd0, addr1}, 32'd14);
    rst = 1'b0;
    tick();

    // "Hi" with ready tied high: exact cycle timing.
    load_text("Hi", 0);
    clear_mon();
    ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    record(15);
    chk("hi_busy1", {31'd0, br[1]}, 32'd1);
    chk("hi_v2", {31'd0, vr[2]}, 32'd0);
    chk("hi_v3", {31'd0, vr[3]}, 32'd1);
    chk("hi_d3", {24'd0, dd[3]}, 32'h48);
    chk("hi_v4", {31'd0, vr[4]}, 32'd0);
    chk("hi_v6", {31'd0, vr[6]}, 32'd1);
    chk("hi_d6", {24'd0, dd[6]}, 32'h69);
    chk("hi_done_prev", {31'd0, dr[HI_DONE-1]}, 32'd0);
    chk("hi_done", {31'd0, dr[HI_DONE]}, 32'd1);
    chk("hi_busy_at_done", {31'd0, br[HI_DONE]}, 32'd1);
    chk("hi_busy_after", {31'd0, br[HI_DONE+1]}, 32'd0);
    chk("hi_done_pulses", done_cnt, 32'd1);
    chk("hi_count", {27'd0, count}, 32'd2);
    chk("hi_nbytes", obs.size(), 32'(2 + 2 * CRLF));
    if (CRLF != 0) begin
      chk("hi_cr", {24'd0, dd[9]}, 32'h0D);
      chk("hi_lf", {24'd0, dd[10]}, 32'h0A);
    end

    // Empty string timing.
    load_text("", 0);
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    record(8);
    nv = 0;
    for (int c = 1; c <= 8; c++) nv += int'(vr[c]);
    chk("empty_valid_cycles", nv, 32'(2 * CRLF));
    chk("empty_done", {31'd0, dr[EMPTY_DONE]}, 32'd1);
    chk("empty_done_pulses", done_cnt, 32'd1);
    chk("empty_count", {27'd0, count}, 32'd0);
    if (CRLF != 0) begin
      chk("empty_cr", {24'd0, dd[3]}, 32'h0D);
      chk("empty_lf", {24'd0, dd[4]}, 32'h0A);
    end

    // Table-driven messages.
    for (int r = 0; r < 6; r++) begin
      load_text(vecs[r].text, vecs[r].sel != 0 ? 14 : 0);
      run_msg(vecs[r].sel, vecs[r].stall, vecs[r].noise, $sformatf("vec%0d", r));
      chk($sformatf("vec%0d_tbl_count", r), {27'd0, count}, vecs[r].exp_count);
      if (vecs[r].sel != 0) chk("vec_wrap", {31'd0, saw_wrap}, 32'd1);
    end
    sel = 1'b0;

    // Reset asserted while the second byte is stalled in SEND.
    load_text("Hi", 0);
    #1;
    clear_mon();
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!tx_valid && k < 10) begin tick(); k++; end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    k = 0;
    while (!tx_valid && k < 10) begin tick(); k++; end
    chk("rsend_second_valid", {31'd0, tx_valid}, 32'd1);
    chk("rsend_count_before", {27'd0, count}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rsend_addr", {28'd0, rom_addr}, 32'd0);
    chk("rsend_data", {24'd0, tx_data}, 32'd0);
    chk("rsend_valid", {31'd0, tx_valid}, 32'd0);
    chk("rsend_busy", {31'd0, busy}, 32'd0);
    chk("rsend_done", {31'd0, done}, 32'd0);
    chk("rsend_count", {27'd0, count}, 32'd0);
    tick();
    rst = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    chk("rsend_idle_after", {31'd0, busy}, 32'd0);
    chk("rsend_no_done", done_cnt, 32'd0);

    // Randomized ROM contents, instance, stalls and stray starts.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 16; i++)
        rom_mem[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_msg(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)) - 1,
              $urandom_range(0, 1) != 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
